// File: rtl/lcd_read_cycle.sv
// rtl/lcd_read_cycle.sv - HD44780 8-bit read-cycle engine with busy-flag polling
// Drives RS/RW/E for single reads or repeated BF reads until BF clears or attempts run out.

module lcd_read_cycle #(
  parameter int T_AS     = 4,
  parameter int T_EH     = 32,
  parameter int T_EL     = 32,
  parameter int POLL_MAX = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       req_rs,
  input  logic       req_poll,
  output logic       ready,
  output logic       bus_busy,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       timeout,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  input  logic [7:0] lcd_data_in
);

  localparam int TMAX_AS_EH = (T_AS > T_EH) ? T_AS : T_EH;
  localparam int TMAX       = (TMAX_AS_EH > T_EL) ? TMAX_AS_EH : T_EL;
  localparam int CW         = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int AW         = (POLL_MAX > 0) ? $clog2(POLL_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EHIGH,
    S_ELOW,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] att_q, att_d;
  logic          poll_q, poll_d;
  logic [7:0]    sample_q, sample_d;
  logic          lcd_e_q, lcd_e_d;
  logic          lcd_rw_q, lcd_rw_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          timeout_q, timeout_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      att_q     <= '0;
      poll_q    <= 1'b0;
      sample_q  <= 8'h00;
      lcd_e_q   <= 1'b0;
      lcd_rw_q  <= 1'b0;
      lcd_rs_q  <= 1'b0;
      rdata_q   <= 8'h00;
      rvalid_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      att_q     <= att_d;
      poll_q    <= poll_d;
      sample_q  <= sample_d;
      lcd_e_q   <= lcd_e_d;
      lcd_rw_q  <= lcd_rw_d;
      lcd_rs_q  <= lcd_rs_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    att_d     = att_q;
    poll_d    = poll_q;
    sample_d  = sample_q;
    lcd_e_d   = lcd_e_q;
    lcd_rw_d  = lcd_rw_q;
    lcd_rs_d  = lcd_rs_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        lcd_e_d  = 1'b0;
        lcd_rw_d = 1'b0;
        if (req) begin
          // Poll only makes sense on the BF/AC register.
          poll_d   = req_poll & ~req_rs;
          att_d    = AW'(1);
          lcd_rw_d = 1'b1;
          lcd_rs_d = req_rs;
          cnt_d    = CW'(T_AS - 1);
          state_d  = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == '0) begin
          lcd_e_d = 1'b1;
          cnt_d   = CW'(T_EH - 1);
          state_d = S_EHIGH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_EHIGH: begin
        if (cnt_q == '0) begin
          sample_d = lcd_data_in;
          lcd_e_d  = 1'b0;
          cnt_d    = CW'(T_EL - 1);
          state_d  = S_ELOW;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_ELOW: begin
        if (cnt_q == '0) begin
          if (poll_q && sample_q[7] && (att_q < AW'(POLL_MAX))) begin
            att_d   = att_q + AW'(1);
            cnt_d   = CW'(T_AS - 1);
            state_d = S_SETUP;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DONE: begin
        rdata_d   = sample_q;
        rvalid_d  = 1'b1;
        timeout_d = poll_q & sample_q[7];
        lcd_rw_d  = 1'b0;
        lcd_rs_d  = 1'b0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready    = (state_q == S_IDLE);
  assign bus_busy = (state_q != S_IDLE);
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign timeout  = timeout_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = lcd_rw_q;
  assign lcd_e    = lcd_e_q;

endmodule

// File: tb/tb_lcd_read_cycle.sv
// tb/tb_lcd_read_cycle.sv - scoreboard bench for lcd_read_cycle
// Driver pushes expected completions; a negedge monitor pops them on rvalid.

module tb_lcd_read_cycle;

  localparam int CYC = 68;  // T_AS + T_EH + T_EL at default timing

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       req_rs = 1'b0;
  logic       req_poll = 1'b0;
  logic       ready, bus_busy, rvalid, timeout, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] rdata;
  logic [7:0] lcd_data_in = 8'h00;

  lcd_read_cycle #(.T_AS(4), .T_EH(32), .T_EL(32), .POLL_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rs(req_rs), .req_poll(req_poll),
    .ready(ready), .bus_busy(bus_busy), .rdata(rdata), .rvalid(rvalid),
    .timeout(timeout), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data_in(lcd_data_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       to;
    int         at_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] vals[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         epulses = 0;
  int         ehigh_w = 0;
  logic       prev_e = 1'b0;
  logic       exp_rs = 1'b0;
  logic       chk_width = 1'b1;
  logic       flip_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor and LCD bus model, both sampled mid-cycle.
  always @(negedge clk) begin
    if (rvalid) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rdata", rdata, e.data);
        check("timeout", timeout, e.to);
        check("rvalid_cycle", cyc, e.at_cyc);
      end
    end
    if (lcd_e && !prev_e) begin
      epulses++;
      ehigh_w = 1;
      check("rs_at_e_rise", lcd_rs, exp_rs);
      check("rw_at_e_rise", lcd_rw, 1);
      if (vals.size() > 0) lcd_data_in = vals.pop_front();
    end else if (lcd_e) begin
      ehigh_w++;
      if (lcd_rs !== exp_rs) check("rs_during_e", lcd_rs, exp_rs);
    end else if (prev_e) begin
      if (chk_width) check("e_high_width", ehigh_w, 32);
      if (flip_en) lcd_data_in = 8'hFF;
    end
    prev_e = lcd_e;
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("wait_ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic rs, input logic poll, input logic [7:0] d,
                       input logic to, input int attempts);
    exp_t e;
    wait_ready();
    req = 1'b1; req_rs = rs; req_poll = poll; exp_rs = rs;
    e.data = d; e.to = to; e.at_cyc = cyc + 1 + CYC * attempts + 1;
    sb.push_back(e);
    @(negedge clk);
    req = 1'b0; req_poll = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_lcd_e", lcd_e, 0);
    check("rst_lcd_rw", lcd_rw, 0);
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_ready", ready, 1);
    check("rst_bus_busy", bus_busy, 0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_rvalid", rvalid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single data read
    epulses = 0;
    vals.push_back(8'h41);
    issue(1'b1, 1'b0, 8'h41, 1'b0, 1);
    check("busy_after_accept", bus_busy, 1);
    check("rw_after_accept", lcd_rw, 1);
    check("rs_after_accept", lcd_rs, 1);
    wait_drain();
    check("single_pulses", epulses, 1);
    check("rvalid_drops", rvalid, 0);
    check("rw_back_low", lcd_rw, 0);
    check("rdata_holds", rdata, 8'h41);

    // Reset mid-EHIGH
    vals.push_back(8'h77);
    wait_ready();
    req = 1'b1; req_rs = 1'b1; exp_rs = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    check("in_ehigh", lcd_e, 1);
    chk_width = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_lcd_e", lcd_e, 0);
    check("midrst_lcd_rw", lcd_rw, 0);
    check("midrst_ready", ready, 1);
    check("midrst_rdata", rdata, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_width = 1'b1;
    vals.delete();

    // Poll: BF set for three reads, then clear
    epulses = 0;
    vals.push_back(8'h80); vals.push_back(8'h80); vals.push_back(8'h80); vals.push_back(8'h05);
    issue(1'b0, 1'b1, 8'h05, 1'b0, 4);
    wait_drain();
    check("poll_pulses", epulses, 4);

    // Poll: BF stuck, exhausts POLL_MAX=8
    epulses = 0;
    for (int i = 0; i < 8; i++) vals.push_back(8'h9F);
    issue(1'b0, 1'b1, 8'h9F, 1'b1, 8);
    wait_drain();
    check("stuck_pulses", epulses, 8);

    // req with rs=1 and poll=1 is a single data read
    epulses = 0;
    vals.push_back(8'h80);
    issue(1'b1, 1'b1, 8'h80, 1'b0, 1);
    wait_drain();
    check("rs1_poll_pulses", epulses, 1);

    // req pulsed while busy is dropped
    vals.push_back(8'h33);
    issue(1'b0, 1'b0, 8'h33, 1'b0, 1);
    repeat (10) @(negedge clk);
    check("busy_not_ready", ready, 0);
    req = 1'b1; req_rs = 1'b1;
    @(negedge clk);
    req = 1'b0; req_rs = 1'b0;
    wait_drain();
    repeat (80) @(negedge clk);
    check("ignored_req_idle", bus_busy, 0);

    // req held high: second read accepted right after return to IDLE
    begin
      exp_t e;
      int t;
      vals.push_back(8'h11); vals.push_back(8'h22);
      wait_ready();
      req = 1'b1; req_rs = 1'b1; exp_rs = 1'b1;
      t = cyc + 1;
      e.data = 8'h11; e.to = 1'b0; e.at_cyc = t + 69;  sb.push_back(e);
      e.data = 8'h22; e.to = 1'b0; e.at_cyc = t + 139; sb.push_back(e);
      repeat (71) @(negedge clk);
      req = 1'b0;
      check("b2b_second_started", bus_busy, 1);
      wait_drain();
    end

    // Data changes after E falls must not leak into rdata
    vals.push_back(8'h00);
    flip_en = 1'b1;
    issue(1'b1, 1'b0, 8'h00, 1'b0, 1);
    wait_drain();
    flip_en = 1'b0;

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
